// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the 16-bit pipelined core.
// Tracks EX/MEM/WB register usage and drives EX operand mux selects.
module fwd_hazard_unit #(
  parameter int RA_W     = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_src1,
  input  logic [RA_W-1:0] id_src2,
  input  logic            id_src1_used,
  input  logic            id_src2_used,
  input  logic [RA_W-1:0] id_dest,
  input  logic            id_wb_en,
  input  logic            id_mem_read,
  output logic [1:0]      fwd_sel1,
  output logic [1:0]      fwd_sel2,
  output logic            stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] src1;
    logic [RA_W-1:0] src2;
    logic            src1_used;
    logic            src2_used;
    logic [RA_W-1:0] dest;
    logic            wb_en;
    logic            mem_read;
  } ex_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dest;
    logic            wb_en;
  } wr_t;

  ex_t ex_q;
  wr_t mem_q;
  wr_t wb_q;
  ex_t ex_d;

  function automatic logic wr(
    input logic            v,
    input logic            we,
    input logic [RA_W-1:0] d,
    input logic [RA_W-1:0] r
  );
    return v && we && (d == r)
      && !(ZERO_REG && (d == '0));
  endfunction

  logic mem_w1, mem_w2;
  logic wb_w1, wb_w2;
  logic ex_ld, id_hit;

  assign mem_w1 = wr(mem_q.valid, mem_q.wb_en,
                     mem_q.dest, ex_q.src1);
  assign mem_w2 = wr(mem_q.valid, mem_q.wb_en,
                     mem_q.dest, ex_q.src2);
  assign wb_w1  = wr(wb_q.valid, wb_q.wb_en,
                     wb_q.dest, ex_q.src1);
  assign wb_w2  = wr(wb_q.valid, wb_q.wb_en,
                     wb_q.dest, ex_q.src2);

  // Newest producer (MEM) takes priority over WB.
  always_comb begin
    fwd_sel1 = 2'd0;
    if (ex_q.valid && ex_q.src1_used) begin
      if (mem_w1)
        fwd_sel1 = 2'd1;
      else if (wb_w1)
        fwd_sel1 = 2'd2;
    end
  end

  always_comb begin
    fwd_sel2 = 2'd0;
    if (ex_q.valid && ex_q.src2_used) begin
      if (mem_w2)
        fwd_sel2 = 2'd1;
      else if (wb_w2)
        fwd_sel2 = 2'd2;
    end
  end

  assign ex_ld = ex_q.valid && ex_q.mem_read
    && ex_q.wb_en
    && !(ZERO_REG && (ex_q.dest == '0));

  assign id_hit =
    (id_src1_used && (id_src1 == ex_q.dest)) ||
    (id_src2_used && (id_src2 == ex_q.dest));

  assign stall = id_valid && ex_ld && id_hit
    && !flush && !freeze;

  always_comb begin
    ex_d = '0;
    if (!(stall || flush)) begin
      ex_d.valid     = id_valid;
      ex_d.src1      = id_src1;
      ex_d.src2      = id_src2;
      ex_d.src1_used = id_src1_used;
      ex_d.src2_used = id_src2_used;
      ex_d.dest      = id_dest;
      ex_d.wb_en     = id_wb_en;
      ex_d.mem_read  = id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else if (!freeze) begin
      wb_q        <= mem_q;
      mem_q.valid <= ex_q.valid;
      mem_q.dest  <= ex_q.dest;
      mem_q.wb_en <= ex_q.wb_en;
      ex_q        <= ex_d;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed vectors push
// expectations, a negedge monitor pops and compares.
module tb_fwd_hazard_unit;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, freeze, flush;
  logic id_valid, id_src1_used, id_src2_used;
  logic [2:0] id_src1, id_src2, id_dest;
  logic id_wb_en, id_mem_read;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic stall;
  logic [CW-1:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  fwd_hazard_unit #(
    .RA_W(3), .ZERO_REG(1'b1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .freeze(freeze), .flush(flush),
    .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used),
    .id_src2_used(id_src2_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    bit           chk;
    logic [1:0]   s1;
    logic [1:0]   s2;
    logic         st;
    logic [CW-1:0] cnt;
    bit           chkv;
    logic         exv;
  } exp_t;

  exp_t q[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          n_vec++;
          if (fwd_sel1 !== e.s1 || fwd_sel2 !== e.s2 ||
              stall !== e.st || stall_cnt !== e.cnt) begin
            n_bad++;
            $display("FAIL %s: got sel1=%0d sel2=%0d stall=%0b cnt=%0d want sel1=%0d sel2=%0d stall=%0b cnt=%0d",
              e.nm, fwd_sel1, fwd_sel2, stall, stall_cnt,
              e.s1, e.s2, e.st, e.cnt);
          end
        end
        if (e.chkv) begin
          n_vec++;
          if (dut.ex_q.valid !== e.exv) begin
            n_bad++;
            $display("FAIL %s_exv: got %0b want %0b",
              e.nm, dut.ex_q.valid, e.exv);
          end
        end
      end
    end
  end

  task automatic ins(
    input logic v,
    input logic [2:0] s1, input logic u1,
    input logic [2:0] s2, input logic u2,
    input logic [2:0] d,
    input logic we, input logic ld
  );
    id_valid = v;
    id_src1 = s1; id_src1_used = u1;
    id_src2 = s2; id_src2_used = u2;
    id_dest = d; id_wb_en = we; id_mem_read = ld;
  endtask

  task automatic nop();
    ins(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic stepv(
    input string nm, input bit chk,
    input logic [1:0] e1, input logic [1:0] e2,
    input logic es, input logic [CW-1:0] ec,
    input bit chkv, input logic exv
  );
    exp_t e;
    e.nm = nm; e.chk = chk;
    e.s1 = e1; e.s2 = e2; e.st = es; e.cnt = ec;
    e.chkv = chkv; e.exv = exv;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step(
    input string nm, input bit chk,
    input logic [1:0] e1, input logic [1:0] e2,
    input logic es, input logic [CW-1:0] ec
  );
    stepv(nm, chk, e1, e2, es, ec, 1'b0, 1'b0);
  endtask

  initial begin
    int c;
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    ins(1, 3, 1, 3, 1, 3, 1, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++)
      step("reset", 1, 0, 0, 0, 0);
    rst = 1'b1;
    ins(1, 5, 1, 6, 1, 7, 1, 0);
    step("rel_indep", 1, 0, 0, 0, 0);
    nop();
    step("indep_ex", 1, 0, 0, 0, 0);

    ins(1, 1, 1, 2, 1, 3, 1, 0);
    step("add_r3", 1, 0, 0, 0, 0);
    ins(1, 3, 1, 3, 1, 4, 1, 0);
    step("sub_id", 1, 0, 0, 0, 0);
    nop();
    step("exmem_fwd", 1, 1, 1, 0, 0);

    ins(1, 0, 0, 0, 0, 3, 1, 0);
    step("w3", 1, 0, 0, 0, 0);
    ins(1, 6, 1, 0, 0, 5, 1, 0);
    step("unrel", 1, 0, 0, 0, 0);
    ins(1, 3, 1, 0, 0, 6, 1, 0);
    step("rd3_id", 1, 0, 0, 0, 0);
    nop();
    step("memwb_fwd", 1, 2, 0, 0, 0);

    ins(1, 0, 0, 0, 0, 3, 1, 0);
    step("w3a", 1, 0, 0, 0, 0);
    ins(1, 0, 0, 0, 0, 3, 1, 0);
    step("w3b", 1, 0, 0, 0, 0);
    ins(1, 3, 1, 3, 1, 6, 1, 0);
    step("rd3b_id", 1, 0, 0, 0, 0);
    nop();
    step("newest_win", 1, 1, 1, 0, 0);

    ins(1, 1, 1, 0, 0, 2, 1, 1);
    step("lw2", 1, 0, 0, 0, 0);
    ins(1, 2, 1, 5, 1, 6, 1, 0);
    step("lu_stall", 1, 0, 0, 1, 0);
    stepv("lu_bubble", 1, 0, 0, 0, 1, 1, 0);
    nop();
    step("lu_fwd", 1, 2, 0, 0, 1);

    ins(1, 1, 1, 0, 0, 2, 1, 1);
    step("lw2_f", 1, 0, 0, 0, 1);
    flush = 1'b1;
    ins(1, 2, 1, 0, 0, 6, 1, 0);
    step("flush_nostall", 1, 0, 0, 0, 1);
    flush = 1'b0;
    ins(1, 0, 0, 0, 0, 6, 1, 0);
    stepv("flush_bubble", 1, 0, 0, 0, 1, 1, 0);

    ins(1, 6, 1, 0, 0, 2, 1, 1);
    step("lw2_s6", 1, 0, 0, 0, 1);
    freeze = 1'b1;
    ins(1, 2, 1, 5, 1, 6, 1, 0);
    for (int i = 0; i < 4; i++)
      step("freeze_hold", 1, 1, 0, 0, 1);
    freeze = 1'b0;
    step("unfreeze_stall", 1, 1, 0, 1, 1);
    step("unfreeze_bub", 1, 0, 0, 0, 2);
    nop();
    step("unfreeze_fwd", 1, 2, 0, 0, 2);

    ins(1, 0, 0, 0, 0, 0, 1, 0);
    step("w0", 1, 0, 0, 0, 2);
    ins(1, 0, 1, 0, 1, 5, 1, 0);
    step("rd0_id", 1, 0, 0, 0, 2);
    nop();
    step("r0_nofwd", 1, 0, 0, 0, 2);
    ins(1, 0, 0, 0, 0, 0, 1, 1);
    step("lw0", 1, 0, 0, 0, 2);
    ins(1, 0, 1, 0, 0, 6, 1, 0);
    step("lw0_nostall", 1, 0, 0, 0, 2);
    nop();
    step("lw0_nofwd", 1, 0, 0, 0, 2);

    c = 2;
    for (int k = 0; k < (1 << CW) + 5; k++) begin
      ins(1, 0, 0, 0, 0, 2, 1, 1);
      step("sat_lw", 1, 0, 0, 0, CW'(c));
      ins(1, 2, 1, 0, 0, 6, 1, 0);
      step("sat_stall", 1, 0, 0, 1, CW'(c));
      if (c < (1 << CW) - 1) c++;
    end
    nop();
    step("sat_final", 1, 0, 0, 0, 4'hF);

    ins(1, 0, 0, 0, 0, 2, 1, 1);
    step("lw2_r", 1, 0, 0, 0, 4'hF);
    ins(1, 2, 1, 0, 0, 6, 1, 0);
    rst = 1'b0;
    stepv("rst_midstall", 1, 0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    nop();
    step("post_rst", 1, 0, 0, 0, 0);
    step("post_rst2", 1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule
